// File: rtl/apple_spawner.sv
// apple_spawner: keeps NUM_APPLES apple slots filled with random grid cells
// that avoid other apples and every live snake segment, clears a slot when the
// head eats it, and answers per-pixel "apple here?" queries for the renderer.
module apple_spawner #(
    parameter int COORD_W    = 4,
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 12,
    parameter int MAX_LEN    = 50,
    parameter int NUM_APPLES = 2
) (
    input  logic                              clk,
    input  logic                              reset,     // async, active low
    input  logic                              s_reset,   // sync soft reset
    input  logic [COORD_W-1:0]                x,
    input  logic [COORD_W-1:0]                y,
    input  logic [COORD_W-1:0]                randX,
    input  logic [COORD_W-1:0]                randY,
    input  logic                              goodColl,
    // segment i = body[i*2*COORD_W +: 2*COORD_W] = {x, y}; segment 0 is the head
    input  logic [MAX_LEN*2*COORD_W-1:0]      body,
    input  logic [$clog2(MAX_LEN+1)-1:0]      length,
    output logic                              apple,
    output logic [NUM_APPLES*COORD_W-1:0]     appleX,
    output logic [NUM_APPLES*COORD_W-1:0]     appleY,
    output logic [NUM_APPLES-1:0]             appleValid,
    output logic                              busy
);
    localparam int SEG_W  = 2 * COORD_W;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int SLOT_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SCAN, S_PLACE} state_t;

    state_t                          r_state, w_next;
    logic [SLOT_W-1:0]               r_slot;
    logic [LEN_W-1:0]                r_idx;
    logic [COORD_W-1:0]              r_candX, r_candY;
    logic [NUM_APPLES*COORD_W-1:0]   r_appleX, r_appleY;
    logic [NUM_APPLES-1:0]           r_valid;
    logic                            r_apple;

    logic [LEN_W-1:0]                w_len;
    logic                            w_any_free;
    logic [SLOT_W-1:0]               w_free_slot;
    logic                            w_reject;
    logic [SEG_W-1:0]                w_seg;
    logic                            w_hit;
    logic                            w_last;
    logic [NUM_APPLES-1:0]           w_eat;
    logic [NUM_APPLES-1:0]           w_place;
    logic                            w_apple_q;
    logic [COORD_W-1:0]              w_headX, w_headY;

    assign w_headX = body[SEG_W-1:COORD_W];
    assign w_headY = body[COORD_W-1:0];

    // Clamp length, pick lowest empty slot, screen the raw candidate and
    // evaluate eat / query matches against the slot table.
    always_comb begin
        w_len       = (32'(length) > MAX_LEN) ? LEN_W'(MAX_LEN) : length;
        w_any_free  = 1'b0;
        w_free_slot = '0;
        w_reject    = (32'(randX) >= GRID_W) || (32'(randY) >= GRID_H);
        w_eat       = '0;
        w_apple_q   = 1'b0;
        for (int k = NUM_APPLES - 1; k >= 0; k--) begin
            if (!r_valid[k]) begin
                w_any_free  = 1'b1;
                w_free_slot = SLOT_W'(k);
            end
        end
        for (int k = 0; k < NUM_APPLES; k++) begin
            if (r_valid[k] && r_appleX[k*COORD_W +: COORD_W] == randX &&
                r_appleY[k*COORD_W +: COORD_W] == randY)
                w_reject = 1'b1;
            if (goodColl && r_valid[k] && r_appleX[k*COORD_W +: COORD_W] == w_headX &&
                r_appleY[k*COORD_W +: COORD_W] == w_headY)
                w_eat[k] = 1'b1;
            if (r_valid[k] && r_appleX[k*COORD_W +: COORD_W] == x &&
                r_appleY[k*COORD_W +: COORD_W] == y)
                w_apple_q = 1'b1;
        end
    end

    // Live body segment selected by the scan index; no snapshot is kept.
    always_comb begin
        w_seg = '0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LEN_W'(i) == r_idx) w_seg = body[i*SEG_W +: SEG_W];
        w_hit   = (w_seg == {r_candX, r_candY});
        // >= rather than == so a length that shrinks mid-scan still terminates
        w_last  = (32'(r_idx) + 1 >= 32'(w_len));
        w_place = (r_state == S_PLACE) ? (NUM_APPLES'(1) << r_slot) : '0;
    end

    // Spawn FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_free) w_next = S_CHECK;
            S_CHECK: if (!w_reject) w_next = (w_len == '0) ? S_PLACE : S_SCAN;
            S_SCAN: begin
                if (w_hit)       w_next = S_CHECK;
                else if (w_last) w_next = S_PLACE;
            end
            S_PLACE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state register; soft reset wins over any spawn in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_state <= S_IDLE;
        else if (s_reset) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    // Slot table, candidate, scan index and registered query result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot   <= '0;
            r_idx    <= '0;
            r_candX  <= '0;
            r_candY  <= '0;
            r_appleX <= '0;
            r_appleY <= '0;
            r_valid  <= '0;
            r_apple  <= 1'b0;
        end else if (s_reset) begin
            r_slot   <= '0;
            r_idx    <= '0;
            r_candX  <= '0;
            r_candY  <= '0;
            r_appleX <= '0;
            r_appleY <= '0;
            r_valid  <= '0;
            r_apple  <= 1'b0;
        end else begin
            r_apple <= w_apple_q;
            // eaten slots keep their position; the placed slot is never an eaten one
            r_valid <= (r_valid & ~w_eat) | w_place;
            case (r_state)
                S_IDLE:  if (w_any_free) r_slot <= w_free_slot;
                S_CHECK: begin
                    r_candX <= randX;
                    r_candY <= randY;
                    r_idx   <= '0;
                end
                S_SCAN:  if (!w_hit && !w_last) r_idx <= r_idx + LEN_W'(1);
                default: ;
            endcase
            for (int k = 0; k < NUM_APPLES; k++) begin
                if (w_place[k]) begin
                    r_appleX[k*COORD_W +: COORD_W] <= r_candX;
                    r_appleY[k*COORD_W +: COORD_W] <= r_candY;
                end
            end
        end
    end

    assign apple      = r_apple;
    assign appleX     = r_appleX;
    assign appleY     = r_appleY;
    assign appleValid = r_valid;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_apple_spawner.sv
// Bench for apple_spawner: expected spawns (slot, position, latency) and query
// results are queued when stimulus is driven and compared when the DUT answers.
module tb_apple_spawner;
    localparam int CW = 4;
    localparam int ML = 50;
    localparam int NA = 2;
    localparam int LW = $clog2(ML + 1);

    logic              clk = 1'b0;
    logic              reset, s_reset, goodColl;
    logic [CW-1:0]     x, y, randX, randY;
    logic [ML*2*CW-1:0] body;
    logic [LW-1:0]     length;
    logic              apple, busy;
    logic [NA*CW-1:0]  appleX, appleY;
    logic [NA-1:0]     appleValid;

    apple_spawner #(.COORD_W(CW), .GRID_W(16), .GRID_H(12), .MAX_LEN(ML), .NUM_APPLES(NA)) dut (
        .clk(clk), .reset(reset), .s_reset(s_reset), .x(x), .y(y),
        .randX(randX), .randY(randY), .goodColl(goodColl), .body(body),
        .length(length), .apple(apple), .appleX(appleX), .appleY(appleY),
        .appleValid(appleValid), .busy(busy));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct {
        int slot;
        int ex;
        int ey;
        int lat;
    } spawn_t;

    spawn_t sq[$];
    bit     aq[$];

    // reference slot table kept from the bench's own expectations
    bit mv[NA];
    int mx[NA];
    int my[NA];

    function automatic bit model_apple(input int qx, input int qy);
        bit r = 1'b0;
        for (int k = 0; k < NA; k++)
            if (mv[k] && mx[k] == qx && my[k] == qy) r = 1'b1;
        return r;
    endfunction

    function automatic logic [NA-1:0] model_valid();
        logic [NA-1:0] v = '0;
        for (int k = 0; k < NA; k++) v[k] = mv[k];
        return v;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NA; k++) begin
            mv[k] = 1'b0; mx[k] = 0; my[k] = 0;
        end
    endtask

    task automatic set_seg(input int i, input int sx, input int sy);
        body[i*2*CW +: 2*CW] = {CW'(sx), CW'(sy)};
    endtask

    task automatic expect_spawn(input int slot, input int ex, input int ey, input int lat);
        spawn_t s;
        s.slot = slot; s.ex = ex; s.ey = ey; s.lat = lat;
        sq.push_back(s);
    endtask

    // Waits (bounded) for the next queued slot to become valid, then compares.
    task automatic wait_spawn(input string tag);
        spawn_t s;
        int     cnt = 0;
        bit     busy_all = 1'b1;
        if (sq.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
            return;
        end
        s = sq.pop_front();
        while (!appleValid[s.slot] && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (!appleValid[s.slot] && !busy) busy_all = 1'b0;
        end
        check({tag, "_valid"}, 32'(appleValid[s.slot]), 1);
        check({tag, "_lat"}, cnt, s.lat);
        check({tag, "_x"}, 32'(appleX[s.slot*CW +: CW]), s.ex);
        check({tag, "_y"}, 32'(appleY[s.slot*CW +: CW]), s.ey);
        check({tag, "_busy"}, 32'(busy_all), 1);
        mv[s.slot] = 1'b1; mx[s.slot] = s.ex; my[s.slot] = s.ey;
        check({tag, "_vec"}, 32'(appleValid), 32'(model_valid()));
    endtask

    task automatic query(input string tag, input int qx, input int qy);
        x = CW'(qx); y = CW'(qy);
        aq.push_back(model_apple(qx, qy));
        @(negedge clk);
        check(tag, 32'(apple), 32'(aq.pop_front()));
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(appleValid), 0);
        check({tag, "_ax"}, 32'(appleX), 0);
        check({tag, "_ay"}, 32'(appleY), 0);
        check({tag, "_apple"}, 32'(apple), 0);
    endtask

    initial begin
        reset = 1'b0; s_reset = 1'b0; goodColl = 1'b0;
        x = '0; y = '0; randX = 4'd5; randY = 4'd8;
        body = '0; length = LW'(4);
        clear_model();
        set_seg(0, 4, 7); set_seg(1, 4, 7); set_seg(2, 4, 6); set_seg(3, 4, 5);

        // power-on
        repeat (2) @(negedge clk);
        check_clear("por");
        reset = 1'b1;
        expect_spawn(0, 5, 8, 7);
        wait_spawn("spawn0");
        // slot 1 keeps rejecting the duplicate {5,8}
        repeat (5) @(negedge clk);
        check("dup_hold_valid", 32'(appleValid), 32'h1);
        check("dup_hold_busy", 32'(busy), 1);
        randX = 4'd9;
        expect_spawn(1, 9, 8, 6);
        wait_spawn("spawn1");

        // queries
        query("q_hit0", 5, 8);
        query("q_miss", 4, 8);
        query("q_hit1", 9, 8);
        query("q_miss2", 9, 7);

        // soft reset, then body reject at segment 2
        s_reset = 1'b1;
        @(negedge clk);
        check_clear("srst");
        clear_model();
        s_reset = 1'b0;
        set_seg(2, 4, 8);
        randX = 4'd4; randY = 4'd8;
        repeat (2) @(negedge clk);
        check("bodyrej_busy", 32'(busy), 1);
        randX = 4'd10; randY = 4'd3;
        expect_spawn(0, 10, 3, 9);
        wait_spawn("bodyrej");

        // off-grid reject: three CHECK rejects before {2,2}
        randX = 4'd14; randY = 4'd13;
        repeat (4) @(negedge clk);
        check("offgrid_nowrite", 32'(appleValid), 32'h1);
        randX = 4'd2; randY = 4'd2;
        expect_spawn(1, 2, 2, 6);
        wait_spawn("offgrid");

        // eat slot 0
        set_seg(0, 10, 3);
        query("q_pre_eat", 10, 3);
        goodColl = 1'b1;
        @(negedge clk);
        goodColl = 1'b0;
        mv[0] = 1'b0;
        check("eat_valid", 32'(appleValid), 32'(model_valid()));
        check("eat_hold_x", 32'(appleX[0 +: CW]), 10);
        randX = 4'd2; randY = 4'd2;
        @(negedge clk);
        check("eat_apple", 32'(apple), 32'(model_apple(10, 3)));
        repeat (2) @(negedge clk);
        randX = 4'd7; randY = 4'd7;
        expect_spawn(0, 7, 7, 6);
        wait_spawn("respawn");

        // goodColl with head on no apple
        set_seg(0, 1, 1);
        goodColl = 1'b1;
        @(negedge clk);
        goodColl = 1'b0;
        check("noeat_valid", 32'(appleValid), 32'h3);
        repeat (2) @(negedge clk);
        check("noeat_idle", 32'(busy), 0);

        // s_reset during SCAN
        s_reset = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check("mid_srst_scan", 32'(busy), 1);
        s_reset = 1'b1;
        @(negedge clk);
        check_clear("mid_srst");
        s_reset = 1'b0;
        expect_spawn(0, 7, 7, 7);
        wait_spawn("after_srst");

        // async reset during SCAN of slot 1
        randX = 4'd12; randY = 4'd11;
        repeat (2) @(negedge clk);
        check("mid_rst_scan", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_clear("mid_rst");
        clear_model();
        @(negedge clk);
        length = '0;
        reset = 1'b1;
        expect_spawn(0, 12, 11, 3);
        wait_spawn("len0_s0");
        randX = 4'd0; randY = 4'd0;
        expect_spawn(1, 0, 0, 3);
        wait_spawn("len0_s1");
        query("q_final", 0, 0);
        query("q_final_miss", 12, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
